// File: rtl/adc_iq_capture.sv
// adc_iq_capture: offset-binary I/Q ADC capture, integrate-and-dump decimator
// and a small output FIFO with valid/ready handshake and sticky overflow flag.
module adc_iq_capture #(
    parameter int ADC_W      = 6,
    parameter int LOG2_DECIM = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int OUT_W      = ADC_W + LOG2_DECIM
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic [ADC_W-1:0]              adc_i,
    input  logic [ADC_W-1:0]              adc_q,
    output logic [OUT_W-1:0]              out_i,
    output logic [OUT_W-1:0]              out_q,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic signed [ADC_W:0]   s_i, s_q;
    logic signed [OUT_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d, sum_i, sum_q;
    logic [LOG2_DECIM-1:0]   cnt_q, cnt_d;
    logic [2*OUT_W-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]             level_q, level_d;
    logic                    ovf_q, ovf_d, dump, full, pop, push;

    // Inverting the MSB of offset binary yields two's complement; then sign-extend by one bit.
    assign s_i   = {~adc_i[ADC_W-1], ~adc_i[ADC_W-1], adc_i[ADC_W-2:0]};
    assign s_q   = {~adc_q[ADC_W-1], ~adc_q[ADC_W-1], adc_q[ADC_W-2:0]};
    assign sum_i = acc_i_q + OUT_W'(s_i);
    assign sum_q = acc_q_q + OUT_W'(s_q);
    assign dump  = clk_en && (&cnt_q);
    assign full  = level_q == (AW+1)'(FIFO_DEPTH);
    assign pop   = out_valid && out_ready;
    assign push  = dump && (!full || pop);

    always_comb begin
        cnt_d   = clk_en ? cnt_q + 1'b1 : cnt_q;
        acc_i_d = clk_en ? (dump ? '0 : sum_i) : acc_i_q;
        acc_q_d = clk_en ? (dump ? '0 : sum_q) : acc_q_q;
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d   = ovf_q | (dump && full && !pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            if (push) mem_q[wr_q] <= {sum_i, sum_q};
        end
    end

    assign out_valid = level_q != '0;
    assign out_i     = mem_q[rd_q][2*OUT_W-1:OUT_W];
    assign out_q     = mem_q[rd_q][OUT_W-1:0];
    assign level     = level_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_adc_iq_capture.sv
// tb_adc_iq_capture: randomized bench for adc_iq_capture against a queue-based
// model of sample blocks, the output FIFO and the sticky overflow flag.
module tb_adc_iq_capture;
    localparam int DECIM = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0, rst = 1'b1, clk_en = 1'b0, out_ready = 1'b0;
    logic [5:0]        adc_i = 6'd32, adc_q = 6'd32;
    logic signed [7:0] out_i, out_q;
    logic              out_valid, overflow;
    logic [2:0]        level;

    int vectors = 0, miscompares = 0;
    int blk_i[$], blk_q[$], fq_i[$], fq_q[$];
    bit ovf_m;
    logic              exp_v, exp_o;
    logic [2:0]        exp_l;
    logic signed [7:0] exp_i, exp_q;

    adc_iq_capture dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .adc_i(adc_i), .adc_q(adc_q),
        .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    task automatic model_outputs();
        exp_v = fq_i.size() > 0;
        exp_l = 3'(fq_i.size());
        exp_o = ovf_m;
        exp_i = exp_v ? 8'(fq_i[0]) : 8'sd0;
        exp_q = exp_v ? 8'(fq_q[0]) : 8'sd0;
    endtask

    // One clock: drive inputs, advance the model by the same edge, settle past the edge.
    task automatic tick(input bit en, input int ai, input int aq, input bit rdy);
        clk_en = en; adc_i = 6'(ai); adc_q = 6'(aq); out_ready = rdy;
        @(posedge clk);
        if (fq_i.size() > 0 && rdy) begin
            void'(fq_i.pop_front());
            void'(fq_q.pop_front());
        end
        if (en) begin
            blk_i.push_back(ai - 32);
            blk_q.push_back(aq - 32);
        end
        if (blk_i.size() == DECIM) begin
            int si = blk_i.sum();
            int sq = blk_q.sum();
            blk_i.delete();
            blk_q.delete();
            if (fq_i.size() < DEPTH) begin
                fq_i.push_back(si);
                fq_q.push_back(sq);
            end else ovf_m = 1'b1;
        end
        model_outputs();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_en = 1'b0; out_ready = 1'b0;
        blk_i.delete(); blk_q.delete(); fq_i.delete(); fq_q.delete(); ovf_m = 1'b0;
        model_outputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({out_valid, overflow, level, out_i, out_q} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset: got v=%b o=%b l=%0d i=%0d q=%0d want all zero", out_valid, overflow, level, out_i, out_q);
        end
    endtask

    task automatic test_zero();
        int first = 0;
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            tick(1, 32, 32, 1);
            if (out_valid && first == 0) first = n;
            vectors++;
            if (out_valid !== exp_v || level !== exp_l || overflow !== exp_o || (exp_v && (out_i !== exp_i || out_q !== exp_q))) begin
                miscompares++;
                $display("FAIL zero n=%0d: got v=%b l=%0d o=%b i=%0d q=%0d want v=%b l=%0d o=%b i=%0d q=%0d", n, out_valid, level, overflow, out_i, out_q, exp_v, exp_l, exp_o, exp_i, exp_q);
            end
        end
        vectors++;
        if (first !== 4) begin
            miscompares++;
            $display("FAIL first_valid: got tick %0d want tick 4", first);
        end
    endtask

    task automatic test_extremes();
        for (int n = 0; n < 16; n++) begin
            tick(1, 63, 0, 1);
            vectors++;
            if (out_valid !== exp_v || level !== exp_l || overflow !== exp_o || (exp_v && (out_i !== 8'sd124 || out_q !== -8'sd128))) begin
                miscompares++;
                $display("FAIL extremes n=%0d: got v=%b l=%0d o=%b i=%0d q=%0d want v=%b l=%0d o=%b i=124 q=-128", n, out_valid, level, overflow, out_i, out_q, exp_v, exp_l, exp_o);
            end
        end
    endtask

    task automatic test_alternating();
        int k = 0, words = 0;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            bit en = (n % 2) == 0;
            tick(en, (k % 2) ? 63 : 0, int'($urandom_range(0, 63)), 1);
            if (en) k++;
            if (out_valid) words++;
            vectors++;
            if (out_valid !== exp_v || level !== exp_l || overflow !== exp_o || (exp_v && (out_i !== -8'sd2 || out_q !== exp_q))) begin
                miscompares++;
                $display("FAIL alternating n=%0d: got v=%b l=%0d o=%b i=%0d q=%0d want v=%b l=%0d o=%b i=-2 q=%0d", n, out_valid, level, overflow, out_i, out_q, exp_v, exp_l, exp_o, exp_q);
            end
        end
        vectors++;
        if (words !== 5) begin
            miscompares++;
            $display("FAIL alt_spacing: got %0d words in 40 cycles want 5", words);
        end
    endtask

    task automatic test_overflow();
        int pops = 0;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            tick(1, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0);
            vectors++;
            if (out_valid !== exp_v || level !== exp_l || overflow !== exp_o || (exp_v && (out_i !== exp_i || out_q !== exp_q))) begin
                miscompares++;
                $display("FAIL ovf_fill n=%0d: got v=%b l=%0d o=%b i=%0d q=%0d want v=%b l=%0d o=%b i=%0d q=%0d", n, out_valid, level, overflow, out_i, out_q, exp_v, exp_l, exp_o, exp_i, exp_q);
            end
        end
        vectors++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flag: got l=%0d o=%b want l=4 o=1", level, overflow);
        end
        for (int n = 0; n < 6; n++) begin
            if (out_valid) pops++;
            tick(0, 32, 32, 1);
            vectors++;
            if (out_valid !== exp_v || level !== exp_l || overflow !== exp_o || (exp_v && (out_i !== exp_i || out_q !== exp_q))) begin
                miscompares++;
                $display("FAIL ovf_drain n=%0d: got v=%b l=%0d o=%b i=%0d q=%0d want v=%b l=%0d o=%b i=%0d q=%0d", n, out_valid, level, overflow, out_i, out_q, exp_v, exp_l, exp_o, exp_i, exp_q);
            end
        end
        vectors++;
        if (pops !== 4) begin
            miscompares++;
            $display("FAIL ovf_pops: got %0d want 4", pops);
        end
    endtask

    task automatic test_full_pop();
        int last_i = 0;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            tick(1, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), n == 19);
            vectors++;
            if (out_valid !== exp_v || level !== exp_l || overflow !== exp_o || (exp_v && (out_i !== exp_i || out_q !== exp_q))) begin
                miscompares++;
                $display("FAIL full_pop n=%0d: got v=%b l=%0d o=%b i=%0d q=%0d want v=%b l=%0d o=%b i=%0d q=%0d", n, out_valid, level, overflow, out_i, out_q, exp_v, exp_l, exp_o, exp_i, exp_q);
            end
        end
        last_i = fq_i[fq_i.size()-1];
        vectors++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_level: got l=%0d o=%b want l=4 o=0", level, overflow);
        end
        repeat (3) tick(0, 32, 32, 1);
        vectors++;
        if (out_valid !== 1'b1 || level !== 3'd1 || out_i !== 8'(last_i)) begin
            miscompares++;
            $display("FAIL full_pop_last: got v=%b l=%0d i=%0d want v=1 l=1 i=%0d", out_valid, level, out_i, last_i);
        end
        tick(0, 32, 32, 1);
    endtask

    task automatic test_reset_mid();
        ovf_m = 1'b1;
        for (int n = 0; n < 20; n++) tick(1, 63, 63, 0);
        tick(0, 32, 32, 1);
        tick(1, 63, 63, 1);
        tick(1, 63, 63, 1);
        do_reset();
        vectors++;
        if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_clear: got v=%b l=%0d o=%b want v=0 l=0 o=0", out_valid, level, overflow);
        end
        for (int n = 0; n < 12; n++) begin
            tick(1, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0);
            vectors++;
            if (out_valid !== exp_v || level !== exp_l || overflow !== exp_o || (exp_v && (out_i !== exp_i || out_q !== exp_q))) begin
                miscompares++;
                $display("FAIL reset_mid n=%0d: got v=%b l=%0d o=%b i=%0d q=%0d want v=%b l=%0d o=%b i=%0d q=%0d", n, out_valid, level, overflow, out_i, out_q, exp_v, exp_l, exp_o, exp_i, exp_q);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            tick(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'($urandom_range(0, 2) == 0));
            vectors++;
            if (out_valid !== exp_v || level !== exp_l || overflow !== exp_o || (exp_v && (out_i !== exp_i || out_q !== exp_q))) begin
                miscompares++;
                $display("FAIL random n=%0d: got v=%b l=%0d o=%b i=%0d q=%0d want v=%b l=%0d o=%b i=%0d q=%0d", n, out_valid, level, overflow, out_i, out_q, exp_v, exp_l, exp_o, exp_i, exp_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_extremes();
        test_alternating();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
